// File: rtl/pb_colour_channel_ctrl_if.sv
// Port bundle for pb_colour_channel_ctrl: button/processor inputs, packed colour and selection outputs.
// No handshake: inputs are sampled every cycle and outputs are registered.
interface pb_colour_channel_ctrl_if #(
   parameter int N_CH  = 3,
   parameter int WIDTH = 5,
   parameter int CW    = (N_CH > 1) ? $clog2(N_CH) : 1
);
   logic [2:0]            PB;
   logic                  WE;
   logic [CW-1:0]         WSEL;
   logic [WIDTH-1:0]      WDATA;
   logic [N_CH*WIDTH-1:0] COLOUR_OUT;
   logic [CW-1:0]         CH_SEL;
   logic                  CHANGED;

   modport master (output PB, WE, WSEL, WDATA, input COLOUR_OUT, CH_SEL, CHANGED);
   modport slave  (input PB, WE, WSEL, WDATA, output COLOUR_OUT, CH_SEL, CHANGED);
endinterface

// File: rtl/pb_colour_channel_ctrl.sv
// Push-button colour selector with saturating channels; PB_AUTOREPEAT_EN adds hold-to-repeat stepping.
// A PB press reaches COLOUR_OUT two cycles after it is first sampled; there is no backpressure.
module pb_colour_channel_ctrl #(
   parameter int               N_CH          = 3,
   parameter int               WIDTH         = 5,
   parameter int               STEP          = 1,
   parameter logic [WIDTH-1:0] RESET_VAL     = '0,
   parameter int               REPEAT_DELAY  = 16,
   parameter int               REPEAT_PERIOD = 4,
   parameter int               CW            = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input logic                     CLK,
   input logic                     RESETn,
   pb_colour_channel_ctrl_if.slave bus
);

   localparam logic [WIDTH:0]  MAXV  = {1'b0, {WIDTH{1'b1}}};
   localparam logic [WIDTH:0]  STEPV = (WIDTH+1)'(STEP);
   localparam logic [CW-1:0]   LAST  = CW'(N_CH - 1);
   localparam logic [CW:0]     NCH_V = (CW+1)'(N_CH);

   if (N_CH < 1 || STEP < 1 || STEP > (1 << WIDTH) - 1 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 1)
   begin : g_param_check
      $error("pb_colour_channel_ctrl: illegal parameter set");
   end

`ifdef PB_AUTOREPEAT_EN
   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int CNTW    = $clog2(CNT_MAX + 1);
   localparam logic [CNTW-1:0] DLY_LAST = CNTW'(REPEAT_DELAY - 1);
   localparam logic [CNTW-1:0] PER_LAST = CNTW'(REPEAT_PERIOD - 1);
   typedef enum logic [1:0] {S_IDLE, S_STEP, S_HOLD, S_RPT} state_t;
   logic [CNTW-1:0] cnt;
`else
   typedef enum logic {S_IDLE, S_STEP} state_t;
`endif

   state_t                     state;
   logic                       dir;
   logic [2:0]                 sync1, sync2, prev, arm;
   logic [1:0]                 sync_vld;
   logic [N_CH-1:0][WIDTH-1:0] colour, colour_nxt;
   logic [CW-1:0]              ch_sel, ch_sel_nxt;
   logic                       changed;
   logic [2:0]                 rise;
   logic                       up_ok, dn_ok, held_ok;
   logic                       step_req, step_up;
   logic [WIDTH:0]             cur;
   logic [WIDTH-1:0]           stepped;

   // A button held through reset stays disarmed until it has been seen released.
   assign rise    = sync2 & ~prev & arm;
   assign up_ok   = sync2[2] & ~sync2[0];
   assign dn_ok   = sync2[0] & ~sync2[2];
   assign held_ok = dir ? up_ok : dn_ok;

   always_comb begin
      step_req = 1'b0;
      step_up  = dir;
      case (state)
         S_IDLE: begin
            if (rise[2] && !sync2[0]) begin
               step_req = 1'b1;
               step_up  = 1'b1;
            end else if (rise[0] && !sync2[2]) begin
               step_req = 1'b1;
               step_up  = 1'b0;
            end
         end
`ifdef PB_AUTOREPEAT_EN
         S_HOLD:  step_req = held_ok && (cnt == DLY_LAST);
         S_RPT:   step_req = held_ok && (cnt == PER_LAST);
`endif
         default: step_req = 1'b0;
      endcase
   end

   always_comb begin
      cur = {1'b0, colour[ch_sel]};
      if (step_up)
         stepped = WIDTH'((cur > MAXV - STEPV) ? MAXV : cur + STEPV);
      else
         stepped = WIDTH'((cur < STEPV) ? '0 : cur - STEPV);
   end

   // One event per cycle: processor write, then channel select, then step.
   always_comb begin
      colour_nxt = colour;
      ch_sel_nxt = ch_sel;
      if (bus.WE) begin
         if ({1'b0, bus.WSEL} < NCH_V)
            colour_nxt[bus.WSEL] = bus.WDATA;
      end else if (rise[1]) begin
         ch_sel_nxt = (ch_sel == LAST) ? '0 : ch_sel + CW'(1);
      end else if (step_req) begin
         colour_nxt[ch_sel] = stepped;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         sync1    <= '0;
         sync2    <= '0;
         prev     <= '0;
         arm      <= '0;
         sync_vld <= '0;
         colour   <= {N_CH{RESET_VAL}};
         ch_sel   <= '0;
         changed  <= 1'b0;
         state    <= S_IDLE;
         dir      <= 1'b0;
`ifdef PB_AUTOREPEAT_EN
         cnt      <= '0;
`endif
      end else begin
         sync1    <= bus.PB;
         sync2    <= sync1;
         prev     <= sync2;
         sync_vld <= {sync_vld[0], 1'b1};
         arm      <= arm | (~sync2 & {3{sync_vld[1]}});
         colour   <= colour_nxt;
         ch_sel   <= ch_sel_nxt;
         changed  <= (colour_nxt != colour);
         case (state)
            S_IDLE: begin
               if (step_req) begin
                  state <= S_STEP;
                  dir   <= step_up;
`ifdef PB_AUTOREPEAT_EN
                  cnt   <= '0;
`endif
               end
            end
            S_STEP: begin
               if (!held_ok)
                  state <= S_IDLE;
`ifdef PB_AUTOREPEAT_EN
               else begin
                  state <= S_HOLD;
                  cnt   <= cnt + CNTW'(1);
               end
`endif
            end
`ifdef PB_AUTOREPEAT_EN
            S_HOLD: begin
               if (!held_ok)
                  state <= S_IDLE;
               else if (cnt == DLY_LAST) begin
                  state <= S_RPT;
                  cnt   <= '0;
               end else
                  cnt   <= cnt + CNTW'(1);
            end
            S_RPT: begin
               if (!held_ok)
                  state <= S_IDLE;
               else if (cnt == PER_LAST)
                  cnt   <= '0;
               else
                  cnt   <= cnt + CNTW'(1);
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.COLOUR_OUT = colour;
   assign bus.CH_SEL     = ch_sel;
   assign bus.CHANGED    = changed;

endmodule

// File: tb/tb_pb_colour_channel_ctrl.sv
// Randomised and directed bench for pb_colour_channel_ctrl with an event scoreboard.
// Build with PB_AUTOREPEAT_EN defined to exercise hold-to-repeat.
module tb_pb_colour_channel_ctrl;
   localparam int N_CH    = 3;
   localparam int WIDTH   = 5;
   localparam int STEP    = 1;
   localparam int CW      = 2;
   localparam int RPT_DLY = 16;
   localparam int RPT_PER = 4;
   localparam int MAXV    = (1 << WIDTH) - 1;
`ifdef PB_AUTOREPEAT_EN
   localparam int AUTO     = 1;
   localparam int EXP_HOLD = 7;
`else
   localparam int AUTO     = 0;
   localparam int EXP_HOLD = 1;
`endif

   typedef struct {
      int                    cyc;
      logic [N_CH*WIDTH-1:0] col;
      logic [CW-1:0]         sel;
      logic                  chg;
   } ev_t;

   bit   CLK = 1'b0;
   logic RESETn;
   ev_t  sbq[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   pb_colour_channel_ctrl_if #(.N_CH(N_CH), .WIDTH(WIDTH), .CW(CW)) bus ();

   pb_colour_channel_ctrl #(
      .N_CH(N_CH), .WIDTH(WIDTH), .STEP(STEP), .RESET_VAL(5'd0),
      .REPEAT_DELAY(RPT_DLY), .REPEAT_PERIOD(RPT_PER), .CW(CW)
   ) dut (
      .CLK(CLK), .RESETn(RESETn), .bus(bus)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, want);
   endtask

   function automatic logic [63:0] pack(input int c, input logic [N_CH*WIDTH-1:0] col,
                                        input logic [CW-1:0] sel, input logic chg);
      return {14'd0, 32'(c), chg, sel, col};
   endfunction

   // Reference model: a button counts as seen two edges after sampling; held-press
   // steps fall at 0, DLY, DLY+PER, ... cycles after the first step.
   int                    m_cyc = 0;
   logic [N_CH*WIDTH-1:0] m_col = '0;
   logic [CW-1:0]         m_sel = '0;
   logic                  m_chg = 1'b0;
   logic [2:0]            h1 = '1, h2 = '1, h3 = '1;
   int                    act = 0;
   int                    held = 0;

   always @(posedge CLK) begin : model
      logic [N_CH*WIDTH-1:0] pcol;
      logic [CW-1:0]         psel;
      logic [2:0]            cur, old, rise;
      logic                  step, up;
      int                    v;
      m_cyc++;
      pcol = m_col;
      psel = m_sel;
      step = 1'b0;
      up   = 1'b0;
      if (!RESETn) begin
         m_col = '0;
         m_sel = '0;
         m_chg = 1'b0;
         h1 = '1; h2 = '1; h3 = '1;
         act = 0;
         held = 0;
      end else begin
         cur  = h2;
         old  = h3;
         rise = cur & ~old;
         h3 = h2; h2 = h1; h1 = bus.PB;
         if (act != 0) begin
            if ((act == 1 && cur[2] && !cur[0]) || (act == 2 && cur[0] && !cur[2])) begin
               held++;
               if (AUTO == 1 && (held == RPT_DLY || (held > RPT_DLY && (held - RPT_DLY) % RPT_PER == 0))) begin
                  step = 1'b1;
                  up   = (act == 1);
               end
            end else act = 0;
         end else if (rise[2] && !cur[0]) begin
            step = 1'b1; up = 1'b1; act = 1; held = 0;
         end else if (rise[0] && !cur[2]) begin
            step = 1'b1; up = 1'b0; act = 2; held = 0;
         end
         if (bus.WE) begin
            if (int'(bus.WSEL) < N_CH) m_col[int'(bus.WSEL)*WIDTH +: WIDTH] = bus.WDATA;
         end else if (rise[1]) begin
            m_sel = (int'(m_sel) == N_CH - 1) ? '0 : CW'(int'(m_sel) + 1);
         end else if (step) begin
            v = int'(m_col[int'(m_sel)*WIDTH +: WIDTH]);
            if (up) v = (v + STEP > MAXV) ? MAXV : v + STEP;
            else    v = (v < STEP) ? 0 : v - STEP;
            m_col[int'(m_sel)*WIDTH +: WIDTH] = v[WIDTH-1:0];
         end
         m_chg = (m_col != pcol);
      end
      if (m_chg || m_col != pcol || m_sel != psel) sbq.push_back('{m_cyc, m_col, m_sel, m_chg});
   end

   int                    mon_cyc = 0;
   logic [N_CH*WIDTH-1:0] last_col = '0;
   logic [CW-1:0]         last_sel = '0;

   always @(negedge CLK) begin : monitor
      logic [63:0] got, want;
      ev_t         e;
      mon_cyc++;
      if (bus.CHANGED === 1'b1 || bus.COLOUR_OUT !== last_col || bus.CH_SEL !== last_sel) begin
         got = pack(mon_cyc, bus.COLOUR_OUT, bus.CH_SEL, bus.CHANGED);
         if (sbq.size() > 0) begin
            e    = sbq.pop_front();
            want = pack(e.cyc, e.col, e.sel, e.chg);
         end else want = '1;
         chk("output_event", got, want);
         last_col = bus.COLOUR_OUT;
         last_sel = bus.CH_SEL;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic press(input logic [2:0] p, input int hold, input int gap);
      bus.PB = p;
      tick(hold);
      bus.PB = 3'b000;
      tick(gap);
   endtask

   task automatic write(input int sel, input int val);
      bus.WE    = 1'b1;
      bus.WSEL  = CW'(sel);
      bus.WDATA = WIDTH'(val);
      tick(1);
      bus.WE    = 1'b0;
   endtask

   initial begin
      int left;
      RESETn    = 1'b0;
      bus.PB    = 3'b111;
      bus.WE    = 1'b1;
      bus.WSEL  = 2'd1;
      bus.WDATA = 5'd21;
      tick(2);
      chk("reset_colour", bus.COLOUR_OUT, 0);
      chk("reset_sel", bus.CH_SEL, 0);
      chk("reset_changed", bus.CHANGED, 0);
      RESETn = 1'b1;
      bus.PB = 3'b000;
      bus.WE = 1'b0;
      tick(5);

      press(3'b100, 30, 6);
      for (int i = 0; i < 31; i++) press(3'b100, $urandom_range(1, 6), $urandom_range(1, 4));
      tick(3);
      chk("ch0_reaches_max", bus.COLOUR_OUT[WIDTH-1:0], 31);
      press(3'b100, 4, 5);
      chk("ch0_stays_max", bus.COLOUR_OUT[WIDTH-1:0], 31);

      write(0, 0);
      tick(3);
      press(3'b001, 3, 5);
      chk("dec_at_zero", bus.COLOUR_OUT[WIDTH-1:0], 0);
      for (int i = 0; i < 3; i++) begin
         press(3'b010, 2, 3);
         chk("ch_sel_advance", bus.CH_SEL, (i + 1) % N_CH);
      end

      press(3'b101, 3, 5);
      chk("both_pressed_no_step", bus.COLOUR_OUT, 0);
      bus.PB = 3'b100;
      tick(2);
      bus.WE    = 1'b1;
      bus.WSEL  = 2'd1;
      bus.WDATA = 5'd17;
      tick(1);
      bus.WE = 1'b0;
      tick(3);
      bus.PB = 3'b000;
      tick(5);
      chk("write_beats_step", bus.COLOUR_OUT, 15'h0220);
      write(3, $urandom_range(0, MAXV));
      tick(3);
      chk("wsel_out_of_range", bus.COLOUR_OUT, 15'h0220);

      bus.PB = 3'b100;
      tick(40);
      bus.PB = 3'b000;
      tick(8);
      chk("hold_40_cycles", bus.COLOUR_OUT[WIDTH-1:0], EXP_HOLD);

      bus.PB = 3'b100;
      tick(25);
      RESETn = 1'b0;
      tick(1);
      RESETn = 1'b1;
      tick(20);
      chk("reset_mid_hold", bus.COLOUR_OUT, 0);
      bus.PB = 3'b000;
      tick(4);
      press(3'b100, 2, 5);
      chk("repress_after_reset", bus.COLOUR_OUT, 1);

      left = 0;
      for (int c = 0; c < 500; c++) begin
         if (left == 0) begin
            bus.PB = 3'($urandom_range(0, 7));
            left   = $urandom_range(1, 24);
         end
         left--;
         if ($urandom_range(0, 11) == 0) begin
            bus.WE    = 1'b1;
            bus.WSEL  = 2'($urandom_range(0, 3));
            bus.WDATA = 5'($urandom_range(0, MAXV));
         end else bus.WE = 1'b0;
         tick(1);
      end
      bus.PB = 3'b000;
      bus.WE = 1'b0;
      tick(10);
      chk("final_colour", bus.COLOUR_OUT, m_col);
      chk("final_sel", bus.CH_SEL, m_sel);
      chk("queue_drained", sbq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
